// File: rtl/alu_rs_param.sv
// ALU reservation station: DEPTH entries, NCDB-channel operand wakeup, one registered issue stage.
// Optional `define ALURS_AGE_ORDER_EN selects oldest-ready-first; default is lowest-index-ready-first.
module alu_rs_param #(
    parameter int                                DEPTH      = 8,
    parameter int                                NCDB       = 2,
    parameter int                                DATA_W     = 32,
    parameter int                                TAG_W      = 4,
    parameter logic [TAG_W-1:0]                  TAG_FREE   = '0,
    parameter logic [TAG_W-$clog2(DEPTH)-1:0]    TAG_PREFIX = '0,
    parameter int                                NAME_W     = 5,
    parameter int                                OP_W       = 6,
    parameter int                                ADDR_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCDB-1:0]             cdb_en,
    input  logic [NCDB*TAG_W-1:0]       cdb_tag,
    input  logic [NCDB*DATA_W-1:0]      cdb_data,
    input  logic                        alloc_en,
    input  logic [DATA_W-1:0]           alloc_data_o,
    input  logic [DATA_W-1:0]           alloc_data_t,
    input  logic [TAG_W-1:0]            alloc_tag_o,
    input  logic [TAG_W-1:0]            alloc_tag_t,
    input  logic [NAME_W-1:0]           alloc_name,
    input  logic [OP_W-1:0]             alloc_op,
    input  logic [ADDR_W-1:0]           alloc_addr,
    output logic                        alloc_ready,
    output logic [$clog2(DEPTH)-1:0]    alloc_idx,
    input  logic                        flush,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [DATA_W-1:0]           issue_data_o,
    output logic [DATA_W-1:0]           issue_data_t,
    output logic [TAG_W-1:0]            issue_tag,
    output logic [NAME_W-1:0]           issue_name,
    output logic [OP_W-1:0]             issue_op,
    output logic [ADDR_W-1:0]           issue_addr,
    output logic [DEPTH-1:0]            free_status,
    output logic [$clog2(DEPTH):0]      free_cnt
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int WAKE_W = TAG_W + DATA_W;

    // Returns {tag, data} after snooping the CDB; the lowest matching channel wins.
    function automatic logic [WAKE_W-1:0] wake(
        input logic [TAG_W-1:0]       tag_in,
        input logic [DATA_W-1:0]      data_in,
        input logic [NCDB-1:0]        en,
        input logic [NCDB*TAG_W-1:0]  tags,
        input logic [NCDB*DATA_W-1:0] datas
    );
        logic [WAKE_W-1:0] res;
        logic              hit;
        res = {tag_in, data_in};
        hit = 1'b0;
        for (int c = 0; c < NCDB; c++) begin
            if (!hit && (tag_in != TAG_FREE) && en[c] && (tags[c*TAG_W +: TAG_W] == tag_in)) begin
                hit = 1'b1;
                res = {TAG_FREE, datas[c*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [TAG_W-1:0]  tag_o_q  [DEPTH];
    logic [TAG_W-1:0]  tag_o_d  [DEPTH];
    logic [TAG_W-1:0]  tag_t_q  [DEPTH];
    logic [TAG_W-1:0]  tag_t_d  [DEPTH];
    logic [DATA_W-1:0] data_o_q [DEPTH];
    logic [DATA_W-1:0] data_o_d [DEPTH];
    logic [DATA_W-1:0] data_t_q [DEPTH];
    logic [DATA_W-1:0] data_t_d [DEPTH];
    logic [NAME_W-1:0] name_q   [DEPTH];
    logic [NAME_W-1:0] name_d   [DEPTH];
    logic [OP_W-1:0]   op_q     [DEPTH];
    logic [OP_W-1:0]   op_d     [DEPTH];
    logic [ADDR_W-1:0] addr_q   [DEPTH];
    logic [ADDR_W-1:0] addr_d   [DEPTH];

    logic [TAG_W-1:0]  fwd_tag_o  [DEPTH];
    logic [TAG_W-1:0]  fwd_tag_t  [DEPTH];
    logic [DATA_W-1:0] fwd_data_o [DEPTH];
    logic [DATA_W-1:0] fwd_data_t [DEPTH];
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  grant;

    logic [TAG_W-1:0]  new_tag_o, new_tag_t;
    logic [DATA_W-1:0] new_data_o, new_data_t;

    logic [DEPTH-1:0]  free_vec, alloc_sel;
    logic [IDX_W-1:0]  alloc_idx_c, sel_idx;
    logic [CNT_W-1:0]  free_cnt_c;
    logic              alloc_fire, stage_load, sel_valid;

    logic              issue_valid_q, issue_valid_d;
    logic [DATA_W-1:0] issue_data_o_q, issue_data_o_d;
    logic [DATA_W-1:0] issue_data_t_q, issue_data_t_d;
    logic [TAG_W-1:0]  issue_tag_q, issue_tag_d;
    logic [NAME_W-1:0] issue_name_q, issue_name_d;
    logic [OP_W-1:0]   issue_op_q, issue_op_d;
    logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;

    // Incoming operands see the same-cycle broadcast so nothing is lost on the allocate cycle.
    assign {new_tag_o, new_data_o} = wake(alloc_tag_o, alloc_data_o, cdb_en, cdb_tag, cdb_data);
    assign {new_tag_t, new_data_t} = wake(alloc_tag_t, alloc_data_t, cdb_en, cdb_tag, cdb_data);

    genvar gi, gj;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wake
            assign {fwd_tag_o[gi], fwd_data_o[gi]} =
                wake(tag_o_q[gi], data_o_q[gi], cdb_en, cdb_tag, cdb_data);
            assign {fwd_tag_t[gi], fwd_data_t[gi]} =
                wake(tag_t_q[gi], data_t_q[gi], cdb_en, cdb_tag, cdb_data);
            assign ready[gi] = busy_q[gi] && (fwd_tag_o[gi] == TAG_FREE) && (fwd_tag_t[gi] == TAG_FREE);
        end
    endgenerate

`ifdef ALURS_AGE_ORDER_EN
    // age_q[i][j] = 1 means entry i was allocated before entry j.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [DEPTH-1:0] older [DEPTH];

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            for (gj = 0; gj < DEPTH; gj++) begin : g_col
                assign older[gi][gj] = age_q[gj][gi];
            end
            assign grant[gi] = ready[gi] && !(|(ready & older[gi]));
        end
    endgenerate

    always_comb begin
        age_d = age_q;
        if (alloc_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_sel[i]) age_d[i] = '0;
                else              age_d[i] = age_q[i] | alloc_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) age_q <= '{default: '0};
        else        age_q <= age_d;
    end
`else
    assign grant = ready & (~ready + DEPTH'(1));
`endif

    assign free_vec   = ~busy_q;
    assign alloc_sel  = free_vec & (~free_vec + DEPTH'(1));
    assign alloc_fire = alloc_en && (|free_vec) && !flush;
    assign stage_load = !issue_valid_q || issue_ready;
    assign sel_valid  = stage_load && (|ready);

    always_comb begin
        alloc_idx_c = '0;
        sel_idx     = '0;
        free_cnt_c  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_sel[i]) alloc_idx_c = IDX_W'(i);
            if (grant[i])     sel_idx     = IDX_W'(i);
            free_cnt_c = free_cnt_c + CNT_W'(free_vec[i]);
        end
    end

    always_comb begin
        busy_d   = busy_q;
        tag_o_d  = fwd_tag_o;
        tag_t_d  = fwd_tag_t;
        data_o_d = fwd_data_o;
        data_t_d = fwd_data_t;
        name_d   = name_q;
        op_d     = op_q;
        addr_d   = addr_q;
        if (sel_valid) busy_d = busy_d & ~grant;
        if (alloc_fire) begin
            busy_d = busy_d | alloc_sel;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_sel[i]) begin
                    tag_o_d[i]  = new_tag_o;
                    tag_t_d[i]  = new_tag_t;
                    data_o_d[i] = new_data_o;
                    data_t_d[i] = new_data_t;
                    name_d[i]   = alloc_name;
                    op_d[i]     = alloc_op;
                    addr_d[i]   = alloc_addr;
                end
            end
        end
        if (flush) busy_d = '0;
    end

    always_comb begin
        issue_valid_d  = issue_valid_q;
        issue_data_o_d = issue_data_o_q;
        issue_data_t_d = issue_data_t_q;
        issue_tag_d    = issue_tag_q;
        issue_name_d   = issue_name_q;
        issue_op_d     = issue_op_q;
        issue_addr_d   = issue_addr_q;
        if (stage_load) begin
            issue_valid_d = sel_valid;
            if (sel_valid) begin
                issue_data_o_d = fwd_data_o[sel_idx];
                issue_data_t_d = fwd_data_t[sel_idx];
                issue_tag_d    = {TAG_PREFIX, sel_idx};
                issue_name_d   = name_q[sel_idx];
                issue_op_d     = op_q[sel_idx];
                issue_addr_d   = addr_q[sel_idx];
            end
        end
        if (flush) issue_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            tag_o_q        <= '{default: TAG_FREE};
            tag_t_q        <= '{default: TAG_FREE};
            data_o_q       <= '{default: '0};
            data_t_q       <= '{default: '0};
            name_q         <= '{default: '0};
            op_q           <= '{default: '0};
            addr_q         <= '{default: '0};
            issue_valid_q  <= 1'b0;
            issue_data_o_q <= '0;
            issue_data_t_q <= '0;
            issue_tag_q    <= TAG_FREE;
            issue_name_q   <= '0;
            issue_op_q     <= '0;
            issue_addr_q   <= '0;
        end else begin
            busy_q         <= busy_d;
            tag_o_q        <= tag_o_d;
            tag_t_q        <= tag_t_d;
            data_o_q       <= data_o_d;
            data_t_q       <= data_t_d;
            name_q         <= name_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            issue_valid_q  <= issue_valid_d;
            issue_data_o_q <= issue_data_o_d;
            issue_data_t_q <= issue_data_t_d;
            issue_tag_q    <= issue_tag_d;
            issue_name_q   <= issue_name_d;
            issue_op_q     <= issue_op_d;
            issue_addr_q   <= issue_addr_d;
        end
    end

    assign alloc_ready  = |free_vec;
    assign alloc_idx    = alloc_idx_c;
    assign free_status  = free_vec;
    assign free_cnt     = free_cnt_c;
    assign issue_valid  = issue_valid_q;
    assign issue_data_o = issue_data_o_q;
    assign issue_data_t = issue_data_t_q;
    assign issue_tag    = issue_tag_q;
    assign issue_name   = issue_name_q;
    assign issue_op     = issue_op_q;
    assign issue_addr   = issue_addr_q;

endmodule
